// File: rtl/accum_buffer_bank.sv
// Banked output-activation accumulator: 2-stage RMW per bank, clear/flush/drain FSM.
// Optional macro ACC_SAT_EN makes the accumulate add saturate instead of wrap.
module accum_buffer_bank #(
    parameter int NUM_BANK = 4,
    parameter int DATA_W   = 16,
    parameter int ACC_W    = 24,
    parameter int OUT_H    = 8,
    parameter int OUT_W    = 8,
    parameter int OUT_K    = 4,
    parameter int CRD_W    = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NUM_BANK-1:0]        in_valid,
    input  logic [NUM_BANK*DATA_W-1:0] in_data,
    input  logic [NUM_BANK*CRD_W-1:0]  in_x,
    input  logic [NUM_BANK*CRD_W-1:0]  in_y,
    input  logic [NUM_BANK*CRD_W-1:0]  in_k,
    input  logic                       clear_start,
    input  logic                       drain_start,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ACC_W-1:0]           out_data,
    output logic [CRD_W-1:0]           out_x,
    output logic [CRD_W-1:0]           out_y,
    output logic [CRD_W-1:0]           out_k,
    output logic                       out_last,
    output logic                       busy,
    output logic                       err
);

    localparam int ROWS  = OUT_H / NUM_BANK;
    localparam int DEPTH = ROWS * OUT_W * OUT_K;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BW    = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_ACCUM = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    function automatic logic [AW-1:0] addr_of(
        input logic [CRD_W-1:0] x,
        input logic [CRD_W-1:0] y,
        input logic [CRD_W-1:0] k
    );
        int a;
        a = (int'(k) * ROWS + int'(y) / NUM_BANK) * OUT_W + int'(x);
        return AW'(a);
    endfunction

    function automatic logic [ACC_W-1:0] acc_add(
        input logic [ACC_W-1:0]  acc,
        input logic [DATA_W-1:0] d
    );
        logic [ACC_W:0] s;
        s = {acc[ACC_W-1], acc} + {{(ACC_W - DATA_W + 1){d[DATA_W-1]}}, d};
`ifdef ACC_SAT_EN
        // sign of the (ACC_W+1)-bit result disagrees with bit ACC_W-1 on overflow
        if (s[ACC_W] != s[ACC_W-1])
            return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`endif
        return s[ACC_W-1:0];
    endfunction

    logic [2:0]          state;
    logic [AW-1:0]       clr_addr;
    logic                flush_cnt;
    logic                clr_we;
    logic [NUM_BANK-1:0] acc_ok;
    logic [NUM_BANK-1:0] drop;
    logic [ACC_W-1:0]    bank_rd [NUM_BANK];

    logic                drn_rd;
    logic [AW-1:0]       drn_addr;
    logic                adv;
    logic                d_done;
    logic [CRD_W-1:0]    dx;
    logic [CRD_W-1:0]    dy;
    logic [CRD_W-1:0]    dk;
    logic                r_valid;
    logic [CRD_W-1:0]    r_x;
    logic [CRD_W-1:0]    r_y;
    logic [CRD_W-1:0]    r_k;
    logic [BW-1:0]       r_bank;
    logic                r_last;

    assign busy   = (state != S_IDLE);
    assign clr_we = (state == S_CLEAR);

    genvar g;
    for (g = 0; g < NUM_BANK; g++) begin : g_bank
        logic [CRD_W-1:0]  bx;
        logic [CRD_W-1:0]  by;
        logic [CRD_W-1:0]  bk;
        logic [DATA_W-1:0] bd;
        logic [AW-1:0]     in_addr;
        logic [ACC_W-1:0]  mem [DEPTH];
        logic [ACC_W-1:0]  rd_q;
        logic              s1_valid;
        logic [AW-1:0]     s1_addr;
        logic [DATA_W-1:0] s1_data;
        logic              s2_valid;
        logic [AW-1:0]     s2_addr;
        logic [ACC_W-1:0]  s2_sum;
        logic              fwd;
        logic [ACC_W-1:0]  sum;
        logic              wr_en;
        logic [AW-1:0]     wr_addr;
        logic [ACC_W-1:0]  wr_data;
        logic              rd_en;
        logic [AW-1:0]     rd_addr;

        assign bx = in_x[g*CRD_W +: CRD_W];
        assign by = in_y[g*CRD_W +: CRD_W];
        assign bk = in_k[g*CRD_W +: CRD_W];
        assign bd = in_data[g*DATA_W +: DATA_W];

        assign acc_ok[g] = in_valid[g] && (state == S_ACCUM)
                        && (int'(bx) < OUT_W) && (int'(by) < OUT_H)
                        && (int'(bk) < OUT_K)
                        && ((int'(by) % NUM_BANK) == g);
        assign drop[g]   = in_valid[g] && !acc_ok[g];
        assign in_addr   = addr_of(bx, by, bk);

        // the previous packet's sum is not yet in memory when this read was issued
        assign fwd = s2_valid && (s2_addr == s1_addr);
        assign sum = acc_add(fwd ? s2_sum : rd_q, s1_data);

        assign wr_en   = clr_we || s1_valid;
        assign wr_addr = clr_we ? clr_addr : s1_addr;
        assign wr_data = clr_we ? '0 : sum;
        assign rd_en   = acc_ok[g] || drn_rd;
        assign rd_addr = drn_rd ? drn_addr : in_addr;

        always_ff @(posedge clock) begin
            if (wr_en)
                mem[wr_addr] <= wr_data;
            if (rd_en)
                rd_q <= mem[rd_addr];
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                s1_valid <= 1'b0;
                s1_addr  <= '0;
                s1_data  <= '0;
                s2_valid <= 1'b0;
                s2_addr  <= '0;
                s2_sum   <= '0;
            end else begin
                s1_valid <= acc_ok[g];
                s1_addr  <= in_addr;
                s1_data  <= bd;
                s2_valid <= s1_valid;
                s2_addr  <= s1_addr;
                s2_sum   <= sum;
            end
        end

        assign bank_rd[g] = rd_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            clr_addr  <= '0;
            flush_cnt <= 1'b0;
            err       <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (clear_start) begin
                        state    <= S_CLEAR;
                        clr_addr <= '0;
                    end
                end
                S_CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == AW'(DEPTH - 1))
                        state <= S_ACCUM;
                end
                S_ACCUM: begin
                    if (drain_start) begin
                        state     <= S_FLUSH;
                        flush_cnt <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    flush_cnt <= 1'b1;
                    if (flush_cnt)
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (out_valid && out_ready && out_last)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            if (state == S_IDLE && clear_start)
                err <= 1'b0;
            if (|drop)
                err <= 1'b1;
        end
    end

    // read stage holds its data while stalled because rd_q only updates on a read
    assign adv      = !out_valid || out_ready;
    assign drn_rd   = (state == S_DRAIN) && adv && !d_done;
    assign drn_addr = addr_of(dx, dy, dk);
    assign r_bank   = BW'(int'(r_y) % NUM_BANK);
    assign r_last   = (r_x == CRD_W'(OUT_W - 1))
                   && (r_y == CRD_W'(OUT_H - 1))
                   && (r_k == CRD_W'(OUT_K - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dx        <= '0;
            dy        <= '0;
            dk        <= '0;
            d_done    <= 1'b0;
            r_valid   <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_k       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_k     <= '0;
            out_last  <= 1'b0;
        end else if (state == S_FLUSH) begin
            dx      <= '0;
            dy      <= '0;
            dk      <= '0;
            d_done  <= 1'b0;
            r_valid <= 1'b0;
        end else if (state == S_DRAIN && adv) begin
            r_valid   <= !d_done;
            r_x       <= dx;
            r_y       <= dy;
            r_k       <= dk;
            out_valid <= r_valid;
            out_last  <= r_valid && r_last;
            if (r_valid) begin
                out_data <= bank_rd[r_bank];
                out_x    <= r_x;
                out_y    <= r_y;
                out_k    <= r_k;
            end
            if (!d_done) begin
                if (dx == CRD_W'(OUT_W - 1)) begin
                    dx <= '0;
                    if (dy == CRD_W'(OUT_H - 1)) begin
                        dy <= '0;
                        if (dk == CRD_W'(OUT_K - 1))
                            d_done <= 1'b1;
                        else
                            dk <= dk + 1'b1;
                    end else begin
                        dy <= dy + 1'b1;
                    end
                end else begin
                    dx <= dx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_accum_buffer_bank.sv
// Scoreboard bench for accum_buffer_bank: clear/accumulate/drain scenarios,
// drop rules, distance-1/2 hazards, stalled drain and wrap/saturate behaviour.
module tb_accum_buffer_bank;

    typedef struct {
        logic [23:0] d;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [7:0]  k;
        logic        last;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  in_valid;
    logic [63:0] in_data;
    logic [31:0] in_x;
    logic [31:0] in_y;
    logic [31:0] in_k;
    logic        clear_start;
    logic        drain_start;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic [7:0]  out_x;
    logic [7:0]  out_y;
    logic [7:0]  out_k;
    logic        out_last;
    logic        busy;
    logic        err;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [23:0] mdl [4][8][8];
    bit          accum_mode;
    bit          exp_err;

    accum_buffer_bank dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_x        (in_x),
        .in_y        (in_y),
        .in_k        (in_k),
        .clear_start (clear_start),
        .drain_start (drain_start),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_x       (out_x),
        .out_y       (out_y),
        .out_k       (out_k),
        .out_last    (out_last),
        .busy        (busy),
        .err         (err)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (reset_n && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL extra_word got d=%h x=%0d y=%0d k=%0d, none expected",
                         out_data, out_x, out_y, out_k);
            end else begin
                mon_e = sb.pop_front();
                if (out_data !== mon_e.d || out_x !== mon_e.x || out_y !== mon_e.y
                    || out_k !== mon_e.k || out_last !== mon_e.last) begin
                    errors++;
                    $display("FAIL drain_word got d=%h x=%0d y=%0d k=%0d last=%b exp d=%h x=%0d y=%0d k=%0d last=%b",
                             out_data, out_x, out_y, out_k, out_last,
                             mon_e.d, mon_e.x, mon_e.y, mon_e.k, mon_e.last);
                end
            end
        end
    end

    function automatic logic [23:0] add_ref(input logic [23:0] a, input logic [15:0] d);
        longint s;
        s = $signed(a) + $signed(d);
`ifdef ACC_SAT_EN
        if (s > 8388607)  s = 8388607;
        if (s < -8388608) s = -8388608;
`endif
        return s[23:0];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, act, exp_v);
        end
    endtask

    task automatic set_pkt(input int b, input int x, input int y, input int k, input logic [15:0] d);
        in_valid[b]          = 1'b1;
        in_data[b*16 +: 16]  = d;
        in_x[b*8 +: 8]       = 8'(x);
        in_y[b*8 +: 8]       = 8'(y);
        in_k[b*8 +: 8]       = 8'(k);
        if (accum_mode && x >= 0 && x < 8 && y >= 0 && y < 8 && k >= 0 && k < 4 && (y % 4) == b)
            mdl[k][y][x] = add_ref(mdl[k][y][x], d);
        else
            exp_err = 1'b1;
    endtask

    task automatic no_pkt();
        in_valid = '0;
        in_data  = '0;
        in_x     = '0;
        in_y     = '0;
        in_k     = '0;
    endtask

    task automatic do_clear();
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        chk("busy_in_clear", {31'd0, busy}, 32'd1);
        chk("err_cleared", {31'd0, err}, 32'd0);
        exp_err = 1'b0;
        for (int k = 0; k < 4; k++)
            for (int y = 0; y < 8; y++)
                for (int x = 0; x < 8; x++)
                    mdl[k][y][x] = '0;
        repeat (66) tick();
        accum_mode = 1'b1;
    endtask

    task automatic start_drain();
        exp_t e;
        for (int k = 0; k < 4; k++)
            for (int y = 0; y < 8; y++)
                for (int x = 0; x < 8; x++) begin
                    e.d = mdl[k][y][x];
                    e.x = 8'(x);
                    e.y = 8'(y);
                    e.k = 8'(k);
                    e.last = (k == 3 && y == 7 && x == 7);
                    sb.push_back(e);
                end
        out_ready   = 1'b1;
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        accum_mode  = 1'b0;
    endtask

    task automatic wait_drain(input string name, input bit toggle);
        logic [3:0] pat;
        bit         done;
        pat  = 4'b1001;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            out_ready = toggle ? pat[i % 4] : 1'b1;
            tick();
            if (sb.size() == 0)
                done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got %0d words left exp 0", name, sb.size());
            sb.delete();
        end
        out_ready = 1'b1;
        chk({name, "_busy_after"}, {31'd0, busy}, 32'd0);
        chk({name, "_valid_after"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        reset_n     = 1'b0;
        clear_start = 1'b0;
        drain_start = 1'b0;
        out_ready   = 1'b0;
        accum_mode  = 1'b0;
        exp_err     = 1'b0;
        no_pkt();
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_last", {31'd0, out_last}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_data", {8'd0, out_data}, 32'd0);
        chk("rst_xyk", {8'd0, out_x, out_y, out_k}, 32'd0);

        // three back-to-back hits to one address, then wrong-parity drops
        do_clear();
        for (int i = 0; i < 3; i++) begin
            set_pkt(0, 1, 0, 0, 16'd5);
            tick();
            no_pkt();
        end
        chk("err_after_good", {31'd0, err}, 32'd0);
        set_pkt(1, 1, 2, 0, 16'd7);
        set_pkt(2, 1, 1, 0, 16'd9);
        tick();
        no_pkt();
        chk("err_wrong_bank", {31'd0, err}, {31'd0, exp_err});
        tick();
        start_drain();
        wait_drain("drain1", 1'b0);
        chk("err_sticky", {31'd0, err}, 32'd1);

        // all banks busy, distance-1 and distance-2 repeats, stalled drain
        do_clear();
        for (int c = 0; c < 100; c++) begin
            for (int b = 0; b < 4; b++) begin
                int x;
                x = (c < 50) ? (c / 2) % 8 : ((c / 4) * 2 + c % 2) % 8;
                set_pkt(b, x, b + 4 * ((c / 8) % 2), (c / 16) % 4,
                        (c % 2 == 0) ? 16'd3 : 16'hFFFF);
            end
            tick();
        end
        no_pkt();
        chk("err_all_good", {31'd0, err}, 32'd0);
        start_drain();
        wait_drain("drain2", 1'b1);

        // packets during FLUSH are dropped, including an underflowed y
        do_clear();
        start_drain();
        set_pkt(0, 0, 255, 0, 16'd9);
        set_pkt(1, 0, 1, 0, 16'd4);
        tick();
        no_pkt();
        chk("err_in_flush", {31'd0, err}, 32'd1);
        wait_drain("drain3", 1'b0);

        // 300 hits of 0x7FFF on one address: wraps, or clamps with ACC_SAT_EN
        do_clear();
        for (int i = 0; i < 300; i++) begin
            set_pkt(3, 7, 7, 3, 16'h7FFF);
            tick();
        end
        no_pkt();
`ifdef ACC_SAT_EN
        chk("sat_ref", {8'd0, mdl[3][7][7]}, 32'h007FFFFF);
`else
        chk("wrap_ref", {8'd0, mdl[3][7][7]}, 32'h0095FED4);
`endif
        start_drain();
        wait_drain("drain4", 1'b1);

        // clear_start is ignored while not idle
        do_clear();
        clear_start = 1'b1;
        set_pkt(0, 2, 4, 1, 16'd11);
        tick();
        clear_start = 1'b0;
        no_pkt();
        tick();
        tick();
        start_drain();
        wait_drain("drain5", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
